// File: rtl/store_unit.sv
// store_unit: SB/SH/SW store path to data memory; word-crossing stores split into two beats.
// Optional MISALIGN_TRAP_EN: misaligned SH/SW are trapped (stMisalign) instead of split. Rev 1.0
`default_nettype none

module store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stValid,
  output logic              stReady,
  input  logic [2:0]        LSCtrl,
  input  logic [ADDR_W-1:0] stAddr,
  input  logic [31:0]       stData,
  output logic              memReq,
  input  logic              memGnt,
  output logic [ADDR_W-1:0] memAddr,
  output logic [31:0]       memWData,
  output logic [3:0]        memWStrb,
  output logic              stDone,
  output logic              stMisalign
);

  localparam logic [2:0] LS_SB = 3'b101;
  localparam logic [2:0] LS_SH = 3'b110;
  localparam logic [2:0] LS_SW = 3'b111;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BEAT0 = 2'd1;
  localparam logic [1:0] BEAT1 = 2'd2;

  logic [1:0]        state;
  logic              split;
  logic [ADDR_W-1:0] beat1_addr;
  logic [31:0]       beat1_data;
  logic [3:0]        beat1_strb;
  logic              done;

  logic              is_store;
  logic              accept;
  logic              trap;
  logic              issue;
  logic [1:0]        off;
  logic [3:0]        mask;
  logic [7:0]        strb8;
  logic [63:0]       data64;
  logic [ADDR_W-1:0] word_addr;

  assign stReady  = (state == IDLE);
  assign memReq   = (state == BEAT0) || (state == BEAT1);
  assign stDone   = done;

  assign is_store = (LSCtrl == LS_SB) || (LSCtrl == LS_SH) || (LSCtrl == LS_SW);
  assign accept   = stValid && stReady && is_store;
  assign off      = stAddr[1:0];

  always_comb begin
    mask = 4'b0001;
    case (LSCtrl)
      LS_SH:   mask = 4'b0011;
      LS_SW:   mask = 4'b1111;
      default: mask = 4'b0001;
    endcase
  end

  // Shift into a two-word window; the upper word is the spill-over beat.
  assign strb8     = {4'b0000, mask} << off;
  assign data64    = {32'h0000_0000, stData} << {off, 3'b000};
  assign word_addr = {stAddr[ADDR_W-1:2], 2'b00};

`ifdef MISALIGN_TRAP_EN
  logic misalign;

  assign trap = ((LSCtrl == LS_SH) && off[0]) || ((LSCtrl == LS_SW) && (off != 2'b00));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign <= 1'b0;
    end else begin
      misalign <= accept && trap;
    end
  end

  assign stMisalign = misalign;
`else
  assign trap       = 1'b0;
  assign stMisalign = 1'b0;
`endif

  assign issue = accept && !trap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      split      <= 1'b0;
      beat1_addr <= '0;
      beat1_data <= 32'h0000_0000;
      beat1_strb <= 4'b0000;
      memAddr    <= '0;
      memWData   <= 32'h0000_0000;
      memWStrb   <= 4'b0000;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (issue) begin
            state      <= BEAT0;
            split      <= |strb8[7:4];
            memAddr    <= word_addr;
            memWData   <= data64[31:0];
            memWStrb   <= strb8[3:0];
            beat1_addr <= word_addr + ADDR_W'(4);
            beat1_data <= data64[63:32];
            beat1_strb <= strb8[7:4];
          end
        end
        BEAT0: begin
          if (memGnt) begin
            if (split) begin
              state    <= BEAT1;
              memAddr  <= beat1_addr;
              memWData <= beat1_data;
              memWStrb <= beat1_strb;
            end else begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        BEAT1: begin
          if (memGnt) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_store_unit.sv
// Directed testbench for store_unit with hand-computed expected bus beats.
`default_nettype none

module tb_store_unit;

  localparam int ADDR_W = 32;
  localparam logic [2:0] SB = 3'b101;
  localparam logic [2:0] SH = 3'b110;
  localparam logic [2:0] SW = 3'b111;
  localparam logic [2:0] LW = 3'b010;

  logic              clk;
  logic              rst_n;
  logic              stValid;
  logic              stReady;
  logic [2:0]        LSCtrl;
  logic [ADDR_W-1:0] stAddr;
  logic [31:0]       stData;
  logic              memReq;
  logic              memGnt;
  logic [ADDR_W-1:0] memAddr;
  logic [31:0]       memWData;
  logic [3:0]        memWStrb;
  logic              stDone;
  logic              stMisalign;

  int checks;
  int errors;

  store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stValid    (stValid),
    .stReady    (stReady),
    .LSCtrl     (LSCtrl),
    .stAddr     (stAddr),
    .stData     (stData),
    .memReq     (memReq),
    .memGnt     (memGnt),
    .memAddr    (memAddr),
    .memWData   (memWData),
    .memWStrb   (memWStrb),
    .stDone     (stDone),
    .stMisalign (stMisalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_beat(input string tag, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s);
    check({tag, ".req"},  {63'd0, memReq}, 64'd1);
    check({tag, ".addr"}, {32'd0, memAddr}, {32'd0, a});
    check({tag, ".data"}, {32'd0, memWData}, {32'd0, d});
    check({tag, ".strb"}, {60'd0, memWStrb}, {60'd0, s});
  endtask

  // Present a request for exactly one active edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    stValid = 1'b1;
    LSCtrl  = op;
    stAddr  = a;
    stData  = d;
    step();
    stValid = 1'b0;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    stValid = 1'b0;
    LSCtrl  = 3'b000;
    stAddr  = '0;
    stData  = 32'h0;
    memGnt  = 1'b0;
    step();
    step();
    check("rst.ready",    {63'd0, stReady}, 64'd1);
    check("rst.req",      {63'd0, memReq}, 64'd0);
    check("rst.addr",     {32'd0, memAddr}, 64'd0);
    check("rst.data",     {32'd0, memWData}, 64'd0);
    check("rst.strb",     {60'd0, memWStrb}, 64'd0);
    check("rst.done",     {63'd0, stDone}, 64'd0);
    check("rst.misalign", {63'd0, stMisalign}, 64'd0);
    #2 rst_n = 1'b1;
    step();

    // SB at byte 3, immediate grant
    memGnt = 1'b1;
    check("t1.ready_pre", {63'd0, stReady}, 64'd1);
    issue(SB, 32'h0000_0103, 32'h0000_00AB);
    check_beat("t1.b0", 32'h0000_0100, 32'hAB00_0000, 4'b1000);
    check("t1.done_early", {63'd0, stDone}, 64'd0);
    check("t1.ready_busy", {63'd0, stReady}, 64'd0);
    step();
    check("t1.done",  {63'd0, stDone}, 64'd1);
    check("t1.ready", {63'd0, stReady}, 64'd1);
    check("t1.req_off", {63'd0, memReq}, 64'd0);
    step();
    check("t1.done_pulse", {63'd0, stDone}, 64'd0);

    // SH aligned, grant held low 5 cycles
    memGnt = 1'b0;
    issue(SH, 32'h0000_0010, 32'h0000_BEEF);
    for (int i = 0; i < 5; i++) begin
      check_beat($sformatf("t3.hold%0d", i), 32'h0000_0010, 32'h0000_BEEF, 4'b0011);
      check($sformatf("t3.ready%0d", i), {63'd0, stReady}, 64'd0);
      check($sformatf("t3.done%0d", i),  {63'd0, stDone}, 64'd0);
      step();
    end
    memGnt = 1'b1;
    check_beat("t3.gnt", 32'h0000_0010, 32'h0000_BEEF, 4'b0011);
    step();
    check("t3.done",  {63'd0, stDone}, 64'd1);
    check("t3.ready", {63'd0, stReady}, 64'd1);
    step();

    // Non-store code is ignored
    issue(LW, 32'h0000_0400, 32'hDEAD_BEEF);
    check("lw.req",   {63'd0, memReq}, 64'd0);
    check("lw.ready", {63'd0, stReady}, 64'd1);
    step();
    check("lw.req2",  {63'd0, memReq}, 64'd0);
    check("lw.done",  {63'd0, stDone}, 64'd0);
    check("lw.misalign", {63'd0, stMisalign}, 64'd0);

`ifndef MISALIGN_TRAP_EN
    // SW at offset 2 splits across two words
    memGnt = 1'b1;
    issue(SW, 32'h0000_0202, 32'h1122_3344);
    check_beat("t2.b0", 32'h0000_0200, 32'h3344_0000, 4'b1100);
    step();
    check_beat("t2.b1", 32'h0000_0204, 32'h0000_1122, 4'b0011);
    check("t2.done_mid", {63'd0, stDone}, 64'd0);
    step();
    check("t2.done", {63'd0, stDone}, 64'd1);
    step();
    check("t2.done_once", {63'd0, stDone}, 64'd0);

    // SW at top of address space: beat1 wraps to 0
    issue(SW, 32'hFFFF_FFFF, 32'hA1B2_C3D4);
    check_beat("t4.b0", 32'hFFFF_FFFC, 32'hD400_0000, 4'b1000);
    step();
    check_beat("t4.b1", 32'h0000_0000, 32'h00A1_B2C3, 4'b0111);
    step();
    check("t4.done", {63'd0, stDone}, 64'd1);
    step();

    // Reset while in BEAT1
    issue(SW, 32'h0000_0303, 32'h5566_7788);
    check_beat("t5.b0", 32'h0000_0300, 32'h8800_0000, 4'b1000);
    memGnt = 1'b0;
    #4;
    memGnt = 1'b1;
    step();
    memGnt = 1'b0;
    check_beat("t5.b1", 32'h0000_0304, 32'h0055_6677, 4'b0111);
`else
    // Misaligned SW traps without a bus request
    memGnt = 1'b1;
    issue(SW, 32'h0000_0201, 32'h1122_3344);
    check("t6.misalign", {63'd0, stMisalign}, 64'd1);
    check("t6.req",      {63'd0, memReq}, 64'd0);
    check("t6.ready",    {63'd0, stReady}, 64'd1);
    step();
    check("t6.misalign_pulse", {63'd0, stMisalign}, 64'd0);
    check("t6.req2",  {63'd0, memReq}, 64'd0);
    check("t6.done",  {63'd0, stDone}, 64'd0);

    // SB at odd offset never traps
    issue(SB, 32'h0000_0201, 32'h0000_0077);
    check("t6.sb_misalign", {63'd0, stMisalign}, 64'd0);
    check_beat("t6.sb", 32'h0000_0200, 32'h0000_7700, 4'b0010);
    step();
    check("t6.sb_done", {63'd0, stDone}, 64'd1);
    step();

    // Reset while a beat is outstanding
    memGnt = 1'b0;
    issue(SW, 32'h0000_0300, 32'h5566_7788);
    check_beat("t5.b0", 32'h0000_0300, 32'h5566_7788, 4'b1111);
`endif
    #2 rst_n = 1'b0;
    #1;
    check("t5.req_drop", {63'd0, memReq}, 64'd0);
    check("t5.ready",    {63'd0, stReady}, 64'd1);
    check("t5.done_rst", {63'd0, stDone}, 64'd0);
    step();
    rst_n  = 1'b1;
    memGnt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("t5.no_done%0d", i), {63'd0, stDone}, 64'd0);
      check($sformatf("t5.idle%0d", i),    {63'd0, memReq}, 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
